// File: rtl/dft2_pair_loader_if.sv
// rtl/dft2_pair_loader_if.sv - sample-in / pair-out handshake bundle for the DFT-2 pair loader
interface dft2_pair_loader_if #(
    parameter int N  = 32,
    parameter int PW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_re;
    logic [N-1:0]  in_im;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  ar;
    logic [N-1:0]  ai;
    logic [N-1:0]  br;
    logic [N-1:0]  bi;
    logic [PW-1:0] out_idx;
    logic          out_last;
    logic          err_odd;

    modport master (
        output in_valid, in_re, in_im, in_last, out_ready,
        input  in_ready, out_valid, ar, ai, br, bi, out_idx, out_last, err_odd
    );

    modport slave (
        input  in_valid, in_re, in_im, in_last, out_ready,
        output in_ready, out_valid, ar, ai, br, bi, out_idx, out_last, err_odd
    );
endinterface

// File: rtl/dft2_pair_loader.sv
// rtl/dft2_pair_loader.sv - pairs consecutive complex samples into a registered (a, b) word for the butterfly
module dft2_pair_loader #(
    parameter int N     = 32,
    parameter int FRAME = 8
) (
    input logic              clk,
    input logic              rst_n,
    dft2_pair_loader_if.slave bus
);
    localparam int PW = ($clog2(FRAME / 2) > 1) ? $clog2(FRAME / 2) : 1;
    localparam int SW = ($clog2(FRAME) > 1) ? $clog2(FRAME) : 1;
    localparam logic [SW-1:0] S_MAX = SW'(FRAME - 1);

    logic [N-1:0]  a_re, a_im;
    logic          has_a, pend;
    logic [SW-1:0] scnt;
    logic [PW-1:0] pcnt;

    logic [N-1:0]  ar_q, ai_q, br_q, bi_q;
    logic [PW-1:0] idx_q;
    logic          last_q, valid_q, err_q;

    logic space, in_ready, accept, frame_end, pair_load, flush, load, load_last;

    always_comb begin
        space     = !valid_q || bus.out_ready;
        // Ready is a function of state and out_ready only, never of in_valid/in_last.
        in_ready  = !pend && (!has_a || space);
        accept    = bus.in_valid && in_ready;
        frame_end = bus.in_last || (scnt == S_MAX);
        pair_load = accept && has_a;
        flush     = pend && space;
        load      = pair_load || flush;
        load_last = flush || frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re    <= '0;
            a_im    <= '0;
            has_a   <= 1'b0;
            pend    <= 1'b0;
            scnt    <= '0;
            pcnt    <= '0;
            ar_q    <= '0;
            ai_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= flush;

            if (accept) begin
                scnt <= frame_end ? '0 : scnt + 1'b1;
            end

            if (accept && !has_a) begin
                a_re  <= bus.in_re;
                a_im  <= bus.in_im;
                has_a <= 1'b1;
                if (frame_end) begin
                    pend <= 1'b1;
                end
            end

            if (pair_load) begin
                has_a <= 1'b0;
            end

            if (flush) begin
                has_a <= 1'b0;
                pend  <= 1'b0;
            end

            // A load wins over a same-cycle drain: the new pair replaces the old one.
            if (load) begin
                ar_q    <= a_re;
                ai_q    <= a_im;
                br_q    <= flush ? '0 : bus.in_re;
                bi_q    <= flush ? '0 : bus.in_im;
                idx_q   <= pcnt;
                last_q  <= load_last;
                pcnt    <= load_last ? '0 : pcnt + 1'b1;
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.ar        = ar_q;
    assign bus.ai        = ai_q;
    assign bus.br        = br_q;
    assign bus.bi        = bi_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.err_odd   = err_q;
endmodule
